// File: rtl/dmem_access_unit_if.sv
// Pipeline-side and memory-side signals of the data-memory access unit.
// The DUT uses the slave modport; the pipeline/memory environment uses master.
interface dmem_access_unit_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int FUNC3_WIDTH = 3
);
  logic                      memReadMeM;
  logic                      memWriteMeM;
  logic [FUNC3_WIDTH-1:0]    func3MeM;
  logic [ADDR_WIDTH-1:0]     addrMeM;
  logic [DATA_WIDTH-1:0]     wdataMeM;
  logic                      stallMem;
  logic [DATA_WIDTH-1:0]     loadDataMem;
  logic                      loadValidMem;
  logic                      accessFault;
  logic [ADDR_WIDTH-1:0]     faultAddr;
  logic                      memReq;
  logic                      memWe;
  logic [ADDR_WIDTH-1:0]     memAddr;
  logic [DATA_WIDTH-1:0]     memWdata;
  logic [DATA_WIDTH/8-1:0]   memBe;
  logic [DATA_WIDTH-1:0]     memRdata;
  logic                      memAck;

  modport slave (
    input  memReadMeM, memWriteMeM, func3MeM, addrMeM, wdataMeM, memRdata, memAck,
    output stallMem, loadDataMem, loadValidMem, accessFault, faultAddr,
           memReq, memWe, memAddr, memWdata, memBe
  );

  modport master (
    output memReadMeM, memWriteMeM, func3MeM, addrMeM, wdataMeM, memRdata, memAck,
    input  stallMem, loadDataMem, loadValidMem, accessFault, faultAddr,
           memReq, memWe, memAddr, memWdata, memBe
  );
endinterface

// File: rtl/dmem_access_unit.sv
// MEM-stage data memory access unit: decodes size/alignment, drives a
// req/ack memory bus with lane shifting, and extends load data.
module dmem_access_unit #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int TIMEOUT     = 255,
  parameter int FUNC3_WIDTH = 3
) (
  input  logic               clk,
  input  logic               rst,
  dmem_access_unit_if.slave  bus
);
  localparam int BEW = DATA_WIDTH / 8;
  localparam int LB  = $clog2(BEW);
  localparam int WW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                  r_state;
  logic [WW-1:0]           r_wait;
  logic                    r_req, r_we, r_loadValid, r_fault, r_isLoad, r_unsigned;
  logic [ADDR_WIDTH-1:0]   r_addr, r_faultAddr;
  logic [DATA_WIDTH-1:0]   r_wdata, r_ldata;
  logic [BEW-1:0]          r_be;
  logic [1:0]              r_size;
  logic [LB-1:0]           r_lane;

  logic                    w_anyAccess, w_oneAccess, w_legal, w_aligned, w_unsigned;
  logic [1:0]              w_size;
  logic [LB-1:0]           w_lane;
  logic [BEW-1:0]          w_beMask;
  logic [DATA_WIDTH-1:0]   w_rsh, w_ldExt;

  assign w_anyAccess = bus.memReadMeM | bus.memWriteMeM;
  assign w_oneAccess = bus.memReadMeM ^ bus.memWriteMeM;
  assign w_lane      = bus.addrMeM[LB-1:0];

  always_comb begin
    w_size     = 2'd0;
    w_legal    = 1'b0;
    w_unsigned = 1'b0;
    w_aligned  = 1'b1;
    w_beMask   = '0;
    // Unsigned codes exist only for loads; D and WU only on a 64-bit bus.
    case (bus.func3MeM)
      FUNC3_WIDTH'(0): begin w_size = 2'd0; w_legal = 1'b1; end
      FUNC3_WIDTH'(1): begin w_size = 2'd1; w_legal = 1'b1; end
      FUNC3_WIDTH'(2): begin w_size = 2'd2; w_legal = 1'b1; end
      FUNC3_WIDTH'(3): begin w_size = 2'd3; w_legal = (DATA_WIDTH == 64); end
      FUNC3_WIDTH'(4): begin w_size = 2'd0; w_unsigned = 1'b1; w_legal = bus.memReadMeM; end
      FUNC3_WIDTH'(5): begin w_size = 2'd1; w_unsigned = 1'b1; w_legal = bus.memReadMeM; end
      FUNC3_WIDTH'(6): begin
        w_size = 2'd2; w_unsigned = 1'b1; w_legal = (DATA_WIDTH == 64) && bus.memReadMeM;
      end
      default: ;
    endcase
    if (!w_oneAccess) w_legal = 1'b0;
    case (w_size)
      2'd1:    begin w_aligned = (bus.addrMeM[0] == 1'b0);   w_beMask = BEW'(4'h3); end
      2'd2:    begin w_aligned = (bus.addrMeM[1:0] == 2'b0); w_beMask = BEW'(4'hF); end
      2'd3:    begin w_aligned = (bus.addrMeM[2:0] == 3'b0); w_beMask = '1; end
      default: begin w_aligned = 1'b1;                       w_beMask = BEW'(4'h1); end
    endcase
  end

  assign w_rsh = bus.memRdata >> {r_lane, 3'b000};

  always_comb begin
    case (r_size)
      2'd0:    w_ldExt = r_unsigned ? DATA_WIDTH'(w_rsh[7:0])  : DATA_WIDTH'($signed(w_rsh[7:0]));
      2'd1:    w_ldExt = r_unsigned ? DATA_WIDTH'(w_rsh[15:0]) : DATA_WIDTH'($signed(w_rsh[15:0]));
      2'd2:    w_ldExt = r_unsigned ? DATA_WIDTH'(w_rsh[31:0]) : DATA_WIDTH'($signed(w_rsh[31:0]));
      default: w_ldExt = w_rsh;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_wait      <= '0;
      r_req       <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_be        <= '0;
      r_ldata     <= '0;
      r_loadValid <= 1'b0;
      r_fault     <= 1'b0;
      r_faultAddr <= '0;
      r_isLoad    <= 1'b0;
      r_unsigned  <= 1'b0;
      r_size      <= 2'd0;
      r_lane      <= '0;
    end else begin
      r_loadValid <= 1'b0;
      r_fault     <= 1'b0;
      case (r_state)
        IDLE: if (w_anyAccess) begin
          if (w_legal && w_aligned) begin
            r_req      <= 1'b1;
            r_we       <= bus.memWriteMeM;
            r_addr     <= {bus.addrMeM[ADDR_WIDTH-1:LB], {LB{1'b0}}};
            r_wdata    <= bus.wdataMeM << {w_lane, 3'b000};
            r_be       <= bus.memWriteMeM ? (w_beMask << w_lane) : '0;
            r_isLoad   <= bus.memReadMeM;
            r_unsigned <= w_unsigned;
            r_size     <= w_size;
            r_lane     <= w_lane;
            r_wait     <= '0;
            r_state    <= BUSY;
          end else begin
            r_fault     <= 1'b1;
            r_faultAddr <= bus.addrMeM;
            r_state     <= DONE;
          end
        end
        BUSY: begin
          if (bus.memAck) begin
            r_req <= 1'b0;
            if (r_isLoad) begin
              r_ldata     <= w_ldExt;
              r_loadValid <= 1'b1;
            end
            r_state <= DONE;
          end else if (TIMEOUT != 0 && r_wait == WW'(TIMEOUT - 1)) begin
            r_req       <= 1'b0;
            r_fault     <= 1'b1;
            r_faultAddr <= bus.addrMeM;
            r_state     <= DONE;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.stallMem     = !rst && ((r_state == IDLE && w_anyAccess) || r_state == BUSY);
  assign bus.memReq       = r_req;
  assign bus.memWe        = r_we;
  assign bus.memAddr      = r_addr;
  assign bus.memWdata     = r_wdata;
  assign bus.memBe        = r_be;
  assign bus.loadDataMem  = r_ldata;
  assign bus.loadValidMem = r_loadValid;
  assign bus.accessFault  = r_fault;
  assign bus.faultAddr    = r_faultAddr;
endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit (32-bit bus, TIMEOUT=4).
module tb_dmem_access_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  dmem_access_unit_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .FUNC3_WIDTH(3)) bus ();

  dmem_access_unit #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(4), .FUNC3_WIDTH(3)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          k;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic        exp_valid;
    logic [31:0] exp_ldata;
    logic        exp_fault;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input int k, input logic exp_req,
                              input logic [31:0] exp_addr, input logic [3:0] exp_be,
                              input logic [31:0] exp_wdata, input logic exp_valid,
                              input logic [31:0] exp_ldata, input logic exp_fault);
    vec_t v;
    v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
    v.k = k; v.exp_req = exp_req; v.exp_addr = exp_addr; v.exp_be = exp_be;
    v.exp_wdata = exp_wdata; v.exp_valid = exp_valid; v.exp_ldata = exp_ldata;
    v.exp_fault = exp_fault;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata);
    bus.memReadMeM  = rd;
    bus.memWriteMeM = wr;
    bus.func3MeM    = f3;
    bus.addrMeM     = addr;
    bus.wdataMeM    = wdata;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    v = vecs[i];
    @(negedge clk);
    drive(v.rd, v.wr, v.f3, v.addr, v.wdata);
    bus.memAck = 1'b0;
    #1;
    chk("stall_t", i, 32'(bus.stallMem), 32'd1);
    chk("req_t", i, 32'(bus.memReq), 32'd0);
    if (v.exp_req) begin
      for (int c = 1; c <= v.k; c++) begin
        @(negedge clk);
        bus.memAck   = (c == v.k);
        bus.memRdata = v.rdata;
        #1;
        chk("stall_busy", i, 32'(bus.stallMem), 32'd1);
        chk("req_busy", i, 32'(bus.memReq), 32'd1);
        if (c == 1) begin
          chk("memAddr", i, bus.memAddr, v.exp_addr);
          chk("memBe", i, 32'(bus.memBe), 32'(v.exp_be));
          chk("memWe", i, 32'(bus.memWe), 32'(v.wr));
          if (v.wr) chk("memWdata", i, bus.memWdata, v.exp_wdata);
        end
      end
    end
    @(negedge clk);
    bus.memAck = 1'b0;
    #1;
    chk("stall_done", i, 32'(bus.stallMem), 32'd0);
    chk("req_done", i, 32'(bus.memReq), 32'd0);
    chk("loadValid", i, 32'(bus.loadValidMem), 32'(v.exp_valid));
    chk("fault", i, 32'(bus.accessFault), 32'(v.exp_fault));
    if (v.exp_valid) chk("loadData", i, bus.loadDataMem, v.exp_ldata);
    if (v.exp_fault) chk("faultAddr", i, bus.faultAddr, v.addr);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //            rd wr f3    addr        wdata         rdata        k  req exp_addr     be       exp_wdata    val exp_ldata    flt
    vecs[0]  = mk(1, 0, 3'd2, 32'h100, 32'h0,        32'hDEADBEEF, 2, 1, 32'h100, 4'b0000, 32'h0,        1, 32'hDEADBEEF, 0);
    vecs[1]  = mk(1, 0, 3'd0, 32'h103, 32'h0,        32'h80123456, 1, 1, 32'h100, 4'b0000, 32'h0,        1, 32'hFFFFFF80, 0);
    vecs[2]  = mk(1, 0, 3'd4, 32'h103, 32'h0,        32'h80123456, 1, 1, 32'h100, 4'b0000, 32'h0,        1, 32'h00000080, 0);
    vecs[3]  = mk(0, 1, 3'd1, 32'h102, 32'h0000ABCD, 32'h0,        1, 1, 32'h100, 4'b1100, 32'hABCD0000, 0, 32'h0,        0);
    vecs[4]  = mk(1, 0, 3'd1, 32'h202, 32'h0,        32'h80011234, 3, 1, 32'h200, 4'b0000, 32'h0,        1, 32'hFFFF8001, 0);
    vecs[5]  = mk(1, 0, 3'd5, 32'h202, 32'h0,        32'h80011234, 1, 1, 32'h200, 4'b0000, 32'h0,        1, 32'h00008001, 0);
    vecs[6]  = mk(0, 1, 3'd0, 32'h301, 32'h000000A5, 32'h0,        1, 1, 32'h300, 4'b0010, 32'h0000A500, 0, 32'h0,        0);
    vecs[7]  = mk(0, 1, 3'd2, 32'h404, 32'h12345678, 32'h0,        2, 1, 32'h404, 4'b1111, 32'h12345678, 0, 32'h0,        0);
    vecs[8]  = mk(1, 0, 3'd0, 32'h100, 32'h0,        32'h0000007F, 1, 1, 32'h100, 4'b0000, 32'h0,        1, 32'h0000007F, 0);
    vecs[9]  = mk(1, 0, 3'd2, 32'h101, 32'h0,        32'h0,        0, 0, 32'h0,   4'b0000, 32'h0,        0, 32'h0,        1);
    vecs[10] = mk(1, 1, 3'd2, 32'h200, 32'h0,        32'h0,        0, 0, 32'h0,   4'b0000, 32'h0,        0, 32'h0,        1);
    vecs[11] = mk(0, 1, 3'd1, 32'h103, 32'h1234,     32'h0,        0, 0, 32'h0,   4'b0000, 32'h0,        0, 32'h0,        1);
    vecs[12] = mk(1, 0, 3'd3, 32'h108, 32'h0,        32'h0,        0, 0, 32'h0,   4'b0000, 32'h0,        0, 32'h0,        1);
    vecs[13] = mk(0, 1, 3'd4, 32'h110, 32'h55,       32'h0,        0, 0, 32'h0,   4'b0000, 32'h0,        0, 32'h0,        1);
    vecs[14] = mk(1, 0, 3'd7, 32'h114, 32'h0,        32'h0,        0, 0, 32'h0,   4'b0000, 32'h0,        0, 32'h0,        1);

    // Reset state; stallMem must stay low under reset even with a request present.
    drive(1'b1, 1'b0, 3'd2, 32'h100, 32'h0);
    bus.memAck   = 1'b0;
    bus.memRdata = '0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_stall", 0, 32'(bus.stallMem), 32'd0);
    chk("rst_req", 0, 32'(bus.memReq), 32'd0);
    chk("rst_we", 0, 32'(bus.memWe), 32'd0);
    chk("rst_addr", 0, bus.memAddr, 32'd0);
    chk("rst_wdata", 0, bus.memWdata, 32'd0);
    chk("rst_be", 0, 32'(bus.memBe), 32'd0);
    chk("rst_ldata", 0, bus.loadDataMem, 32'd0);
    chk("rst_valid", 0, 32'(bus.loadValidMem), 32'd0);
    chk("rst_fault", 0, 32'(bus.accessFault), 32'd0);
    chk("rst_faddr", 0, bus.faultAddr, 32'd0);
    drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back table vectors: each starts the cycle right after the previous DONE.
    for (int i = 0; i < NV; i++) run_vec(i);

    // Timeout: memReq held 4 cycles, then fault pulse with stall released.
    @(negedge clk);
    drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    @(negedge clk);
    drive(1'b1, 1'b0, 3'd2, 32'h500, 32'h0);
    #1;
    chk("to_stall_t", 100, 32'(bus.stallMem), 32'd1);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      #1;
      chk("to_req", 100 + c, 32'(bus.memReq), 32'd1);
      chk("to_stall", 100 + c, 32'(bus.stallMem), 32'd1);
    end
    @(negedge clk);
    #1;
    chk("to_req_done", 105, 32'(bus.memReq), 32'd0);
    chk("to_fault", 105, 32'(bus.accessFault), 32'd1);
    chk("to_stall_done", 105, 32'(bus.stallMem), 32'd0);
    chk("to_faddr", 105, bus.faultAddr, 32'h500);
    chk("to_valid", 105, 32'(bus.loadValidMem), 32'd0);
    // Stray ack while idle must be ignored.
    @(negedge clk);
    drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    bus.memAck = 1'b1;
    @(negedge clk);
    bus.memAck = 1'b0;
    #1;
    chk("idle_ack_valid", 106, 32'(bus.loadValidMem), 32'd0);
    chk("idle_ack_fault", 106, 32'(bus.accessFault), 32'd0);
    chk("idle_ack_req", 106, 32'(bus.memReq), 32'd0);

    // Reset in the second BUSY cycle, stale ack one cycle later.
    @(negedge clk);
    drive(1'b1, 1'b0, 3'd2, 32'h600, 32'h0);
    @(negedge clk);
    #1;
    chk("rb_req1", 200, 32'(bus.memReq), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rb_stall_rst", 201, 32'(bus.stallMem), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    bus.memAck   = 1'b1;
    bus.memRdata = 32'hCAFEF00D;
    #1;
    chk("rb_req", 202, 32'(bus.memReq), 32'd0);
    chk("rb_stall", 202, 32'(bus.stallMem), 32'd0);
    chk("rb_faddr", 202, bus.faultAddr, 32'd0);
    @(negedge clk);
    bus.memAck = 1'b0;
    #1;
    chk("rb_valid", 203, 32'(bus.loadValidMem), 32'd0);
    chk("rb_fault", 203, 32'(bus.accessFault), 32'd0);
    chk("rb_req2", 203, 32'(bus.memReq), 32'd0);
    // FSM is back in IDLE: a fresh access raises stall immediately and is served.
    run_vec(0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
